// File: rtl/isa_pkg.sv
// Shared types for the ISA bus cycle generator: FSM state encoding and
// the four bus cycle types selected by the read and I/O command bits.
package isa_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WDATA  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_STROBE = 3'd3,
      ST_HOLD   = 3'd4
   } isa_state_e;

   typedef enum logic [1:0] {
      CYC_MEMW = 2'd0,
      CYC_MEMR = 2'd1,
      CYC_IOW  = 2'd2,
      CYC_IOR  = 2'd3
   } isa_cyc_e;

   function automatic isa_cyc_e cyc_type(input logic is_read, input logic is_io);
      return isa_cyc_e'({is_io, is_read});
   endfunction

   function automatic logic cyc_is_read(input isa_cyc_e cyc);
      return (cyc == CYC_MEMR) || (cyc == CYC_IOR);
   endfunction

endpackage

// File: rtl/isa_sync2.sv
// Two-flop synchronizer for the asynchronous bus ready line, with a
// synchronous clear so stale ready cannot leak into a new strobe window.
module isa_sync2 (
   input  logic clk,
   input  logic reset_l,
   input  logic srst,
   input  logic d,
   output logic q
);

   logic [1:0] sync_r;

   // synchronizer chain, cleared by reset or soft clear
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         sync_r <= 2'b00;
      end else if (srst) begin
         sync_r <= 2'b00;
      end else begin
         sync_r <= {sync_r[0], d};
      end
   end

   assign q = sync_r[1];

endmodule

// File: rtl/isa_cycle_gen.sv
// ISA bus cycle generator: turns single or burst read/write commands into
// timed address setup, strobe and hold phases with ready stretch and timeout.
module isa_cycle_gen
   import isa_pkg::*;
#(
   parameter int ADDR_W       = 20,
   parameter int DATA_W       = 8,
   parameter int LEN_W        = 8,
   parameter int SETUP_CLKS   = 3,
   parameter int STROBE_CLKS  = 6,
   parameter int HOLD_CLKS    = 4,
   parameter int TIMEOUT_CLKS = 64
) (
   input  logic              clk,
   input  logic              reset_l,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_read,
   input  logic              cmd_io,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              cmd_incr,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] bus_a,
   output logic [DATA_W-1:0] bus_d_out,
   output logic              bus_d_oe,
   input  logic [DATA_W-1:0] bus_d_in,
   output logic              bus_ior_l,
   output logic              bus_iow_l,
   output logic              bus_memr_l,
   output logic              bus_memw_l,
   output logic              bus_aen,
   input  logic              bus_rdy
);

   localparam int CNT_W = 16;

   isa_state_e        state_r, state_s;
   isa_cyc_e          cyc_r, cyc_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [LEN_W-1:0]  left_r, left_s;
   logic [DATA_W-1:0] wdat_r, wdat_s;
   logic              incr_r, incr_s;
   logic              tmo_r, tmo_s;
   logic              rsp_pulse_s, rsp_last_s, rsp_tmo_s;
   logic              rdy_sync_s, sync_clr_s, bus_act_s, strobe_on_s;

   logic              cmd_ready_r, wr_ready_r, bus_d_oe_r, bus_aen_r;
   logic              rsp_valid_r, rsp_last_r, rsp_timeout_r;
   logic [DATA_W-1:0] rsp_data_r, bus_d_out_r;
   logic [ADDR_W-1:0] bus_a_r;
   logic              ior_l_r, iow_l_r, memr_l_r, memw_l_r;

   // Ready is only allowed through once the minimum strobe time has been
   // served, so synchronizer latency stretches the strobe instead of eating it.
   assign sync_clr_s = (state_r != ST_STROBE) || (cnt_r < CNT_W'(STROBE_CLKS - 1));

   isa_sync2 u_rdy_sync (
      .clk     (clk),
      .reset_l (reset_l),
      .srst    (sync_clr_s),
      .d       (bus_rdy),
      .q       (rdy_sync_s)
   );

   // next-state, phase counter and command context
   always_comb begin
      state_s     = state_r;
      cyc_s       = cyc_r;
      cnt_s       = cnt_r;
      addr_s      = addr_r;
      left_s      = left_r;
      wdat_s      = wdat_r;
      incr_s      = incr_r;
      tmo_s       = tmo_r;
      rsp_pulse_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_r) begin
               addr_s  = cmd_addr;
               cyc_s   = cyc_type(cmd_read, cmd_io);
               left_s  = cmd_len;
               incr_s  = cmd_incr;
               tmo_s   = 1'b0;
               cnt_s   = {CNT_W{1'b0}};
               state_s = cmd_read ? ST_SETUP : ST_WDATA;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WDATA: begin
            if (wr_valid && wr_ready_r) begin
               wdat_s  = wr_data;
               cnt_s   = {CNT_W{1'b0}};
               state_s = ST_SETUP;
            end else begin
               state_s = ST_WDATA;
            end
         end
         ST_SETUP: begin
            if (cnt_r == CNT_W'(SETUP_CLKS - 1)) begin
               cnt_s   = {CNT_W{1'b0}};
               state_s = ST_STROBE;
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         ST_STROBE: begin
            if (rdy_sync_s && (cnt_r >= CNT_W'(STROBE_CLKS - 1))) begin
               cnt_s       = {CNT_W{1'b0}};
               rsp_pulse_s = 1'b1;
               state_s     = ST_HOLD;
            end else if (cnt_r == CNT_W'(TIMEOUT_CLKS - 1)) begin
               cnt_s       = {CNT_W{1'b0}};
               tmo_s       = 1'b1;
               rsp_pulse_s = 1'b1;
               state_s     = ST_HOLD;
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_r == CNT_W'(HOLD_CLKS - 1)) begin
               cnt_s = {CNT_W{1'b0}};
               if ((left_r != {LEN_W{1'b0}}) && !tmo_r) begin
                  left_s  = left_r - {{(LEN_W-1){1'b0}}, 1'b1};
                  addr_s  = incr_r ? (addr_r + {{(ADDR_W-1){1'b0}}, 1'b1}) : addr_r;
                  state_s = cyc_is_read(cyc_r) ? ST_SETUP : ST_WDATA;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   assign rsp_last_s  = rsp_pulse_s && ((left_r == {LEN_W{1'b0}}) || tmo_s);
   assign rsp_tmo_s   = rsp_pulse_s && tmo_s;
   assign bus_act_s   = (state_s == ST_SETUP) || (state_s == ST_STROBE) || (state_s == ST_HOLD);
   assign strobe_on_s = (state_s == ST_STROBE);

   // state, context and registered bus/handshake outputs
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_r       <= ST_IDLE;
         cyc_r         <= CYC_MEMW;
         cnt_r         <= {CNT_W{1'b0}};
         addr_r        <= {ADDR_W{1'b0}};
         left_r        <= {LEN_W{1'b0}};
         wdat_r        <= {DATA_W{1'b0}};
         incr_r        <= 1'b0;
         tmo_r         <= 1'b0;
         cmd_ready_r   <= 1'b0;
         wr_ready_r    <= 1'b0;
         rsp_valid_r   <= 1'b0;
         rsp_last_r    <= 1'b0;
         rsp_timeout_r <= 1'b0;
         rsp_data_r    <= {DATA_W{1'b0}};
         bus_a_r       <= {ADDR_W{1'b0}};
         bus_d_out_r   <= {DATA_W{1'b0}};
         bus_d_oe_r    <= 1'b0;
         bus_aen_r     <= 1'b1;
         ior_l_r       <= 1'b1;
         iow_l_r       <= 1'b1;
         memr_l_r      <= 1'b1;
         memw_l_r      <= 1'b1;
      end else begin
         state_r       <= state_s;
         cyc_r         <= cyc_s;
         cnt_r         <= cnt_s;
         addr_r        <= addr_s;
         left_r        <= left_s;
         wdat_r        <= wdat_s;
         incr_r        <= incr_s;
         tmo_r         <= tmo_s;
         cmd_ready_r   <= (state_s == ST_IDLE);
         wr_ready_r    <= (state_s == ST_WDATA);
         rsp_valid_r   <= rsp_pulse_s;
         rsp_last_r    <= rsp_last_s;
         rsp_timeout_r <= rsp_tmo_s;
         rsp_data_r    <= (rsp_pulse_s && cyc_is_read(cyc_r)) ? bus_d_in : {DATA_W{1'b0}};
         bus_a_r       <= (state_s == ST_SETUP) ? addr_s : bus_a_r;
         bus_d_out_r   <= wdat_s;
         bus_d_oe_r    <= bus_act_s && !cyc_is_read(cyc_s);
         bus_aen_r     <= !bus_act_s;
         ior_l_r       <= !(strobe_on_s && (cyc_s == CYC_IOR));
         iow_l_r       <= !(strobe_on_s && (cyc_s == CYC_IOW));
         memr_l_r      <= !(strobe_on_s && (cyc_s == CYC_MEMR));
         memw_l_r      <= !(strobe_on_s && (cyc_s == CYC_MEMW));
      end
   end

   assign cmd_ready   = cmd_ready_r;
   assign wr_ready    = wr_ready_r;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_data    = rsp_data_r;
   assign rsp_last    = rsp_last_r;
   assign rsp_timeout = rsp_timeout_r;
   assign bus_a       = bus_a_r;
   assign bus_d_out   = bus_d_out_r;
   assign bus_d_oe    = bus_d_oe_r;
   assign bus_aen     = bus_aen_r;
   assign bus_ior_l   = ior_l_r;
   assign bus_iow_l   = iow_l_r;
   assign bus_memr_l  = memr_l_r;
   assign bus_memw_l  = memw_l_r;

endmodule

// File: tb/tb_isa_cycle_gen.sv
// Directed bench for isa_cycle_gen: bus monitor plus hand-computed checks
// of strobe widths, addresses, responses, timeout, reset and wraparound.
module tb_isa_cycle_gen;

   logic        clk = 1'b0;
   logic        reset_l;
   logic        cmd_valid, cmd_ready, cmd_read, cmd_io, cmd_incr;
   logic [19:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic        wr_valid, wr_ready;
   logic [7:0]  wr_data;
   logic        rsp_valid, rsp_last, rsp_timeout;
   logic [7:0]  rsp_data;
   logic [19:0] bus_a;
   logic [7:0]  bus_d_out, bus_d_in;
   logic        bus_d_oe, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen, bus_rdy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   isa_cycle_gen dut (
      .clk(clk), .reset_l(reset_l),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_read(cmd_read), .cmd_io(cmd_io), .cmd_len(cmd_len), .cmd_incr(cmd_incr),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_timeout(rsp_timeout),
      .bus_a(bus_a), .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_d_in(bus_d_in),
      .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
      .bus_aen(bus_aen), .bus_rdy(bus_rdy)
   );

   // bus monitor state, sampled on the falling edge
   logic [3:0]  strb_s;
   logic        any_low_s;
   logic        prev_any = 1'b0;
   logic        prev_aen_low = 1'b0;
   logic [19:0] prev_a = 20'h0;
   logic [3:0]  last_type = 4'hF;
   int          n_strobe = 0, cur_width = 0, last_width = 0;
   int          n_rsp = 0, n_rsp_last = 0, aen_low = 0, a_chg = 0, n_multi = 0, n_aen_bad = 0;
   logic [7:0]  last_rsp_data = 8'h0;
   logic        last_rsp_last = 1'b0, last_rsp_tmo = 1'b0;
   logic [19:0] a_log[$];
   logic [7:0]  d_log[$];

   assign strb_s    = {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l};
   assign any_low_s = (strb_s != 4'hF);

   always @(negedge clk) begin
      if (any_low_s && !prev_any) begin
         n_strobe  <= n_strobe + 1;
         cur_width <= 1;
         last_type <= strb_s;
         a_log.push_back(bus_a);
         d_log.push_back(bus_d_out);
      end else if (any_low_s) begin
         cur_width <= cur_width + 1;
      end
      if (!any_low_s && prev_any) last_width <= cur_width;
      if ($countones(~strb_s) > 1) n_multi <= n_multi + 1;
      if (any_low_s && bus_aen) n_aen_bad <= n_aen_bad + 1;
      if (!bus_aen) aen_low <= aen_low + 1;
      if (!bus_aen && prev_aen_low && (bus_a != prev_a)) a_chg <= a_chg + 1;
      if (rsp_valid) begin
         n_rsp         <= n_rsp + 1;
         last_rsp_data <= rsp_data;
         last_rsp_last <= rsp_last;
         last_rsp_tmo  <= rsp_timeout;
         if (rsp_last) n_rsp_last <= n_rsp_last + 1;
      end
      prev_any     <= any_low_s;
      prev_aen_low <= !bus_aen;
      prev_a       <= bus_a;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [19:0] a, input logic rd, input logic io,
                        input logic [7:0] len, input logic inc);
      logic took;
      took = 1'b0;
      cmd_addr = a; cmd_read = rd; cmd_io = io; cmd_len = len; cmd_incr = inc;
      cmd_valid = 1'b1;
      for (int i = 0; i < 400 && !took; i++) begin
         took = cmd_ready;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      chk("cmd_accept", {31'd0, took}, 32'd1);
   endtask

   task automatic send_wdata(input logic [7:0] d, input int gap);
      logic rdy_seen, took;
      rdy_seen = 1'b0;
      took     = 1'b0;
      for (int i = 0; i < 400 && !rdy_seen; i++) begin
         if (wr_ready) rdy_seen = 1'b1;
         else begin @(posedge clk); #1; end
      end
      chk("wr_ready_wait", {31'd0, rdy_seen}, 32'd1);
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
         chk("aen_in_gap", {31'd0, bus_aen}, 32'd1);
      end
      wr_data  = d;
      wr_valid = 1'b1;
      for (int i = 0; i < 400 && !took; i++) begin
         took = wr_ready;
         @(posedge clk); #1;
      end
      wr_valid = 1'b0;
      chk("wr_accept", {31'd0, took}, 32'd1);
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
         @(posedge clk); #1;
         done = cmd_ready;
      end
      chk("idle_wait", {31'd0, done}, 32'd1);
   endtask

   task automatic wait_strobe();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(posedge clk); #1;
         seen = any_low_s;
      end
      chk("strobe_wait", {31'd0, seen}, 32'd1);
   endtask

   int s0, r0, rl0, al0, ac0;

   initial begin
      reset_l = 1'b0; cmd_valid = 1'b0; cmd_addr = 20'h0; cmd_read = 1'b0; cmd_io = 1'b0;
      cmd_len = 8'h0; cmd_incr = 1'b0; wr_valid = 1'b0; wr_data = 8'h0;
      bus_d_in = 8'hAA; bus_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_strobes", {28'd0, strb_s}, 32'hF);
      chk("rst_aen", {31'd0, bus_aen}, 32'd1);
      chk("rst_doe", {31'd0, bus_d_oe}, 32'd0);
      chk("rst_addr", {12'd0, bus_a}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_rsp", {29'd0, rsp_valid, rsp_last, rsp_timeout}, 32'd0);
      reset_l = 1'b1;
      @(posedge clk); #1;
      chk("cmd_ready_rise", {31'd0, cmd_ready}, 32'd1);

      // I/O write, ready high: 6 minimum + 2 synchronizer clocks
      s0 = n_strobe; r0 = n_rsp; al0 = aen_low; ac0 = a_chg;
      issue(20'h003D8, 1'b0, 1'b1, 8'd0, 1'b0);
      send_wdata(8'h0B, 0);
      wait_idle();
      chk("iow_width", last_width, 32'd8);
      chk("iow_type", {28'd0, last_type}, 32'hB);
      chk("iow_count", n_strobe - s0, 32'd1);
      chk("iow_addr", {12'd0, a_log[$]}, 32'h3D8);
      chk("iow_data", {24'd0, d_log[$]}, 32'h0B);
      chk("iow_aen_clks", aen_low - al0, 32'd15);
      chk("iow_a_stable", a_chg - ac0, 32'd0);
      chk("iow_rsp", n_rsp - r0, 32'd1);
      chk("iow_rsp_data", {24'd0, last_rsp_data}, 32'h0);

      // memory read with ready held low for 10 strobe clocks
      bus_rdy = 1'b0; s0 = n_strobe;
      issue(20'hB8055, 1'b1, 1'b0, 8'd0, 1'b0);
      wait_strobe();
      repeat (10) begin @(posedge clk); #1; end
      bus_rdy = 1'b1;
      wait_idle();
      chk("memr_width_min", {31'd0, last_width >= 12}, 32'd1);
      chk("memr_width_max", {31'd0, last_width <= 14}, 32'd1);
      chk("memr_type", {28'd0, last_type}, 32'hD);
      chk("memr_data", {24'd0, last_rsp_data}, 32'hAA);
      chk("memr_last", {30'd0, last_rsp_last, last_rsp_tmo}, 32'h2);

      // burst write with a 5-clock data gap on beat 2
      s0 = n_strobe; r0 = n_rsp; rl0 = n_rsp_last;
      issue(20'hB8000, 1'b0, 1'b0, 8'd3, 1'b1);
      send_wdata(8'h11, 0);
      send_wdata(8'h12, 5);
      send_wdata(8'h13, 0);
      send_wdata(8'h14, 0);
      wait_idle();
      chk("bw_count", n_strobe - s0, 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("bw_addr", {12'd0, a_log[a_log.size() - 4 + k]}, 32'hB8000 + k);
         chk("bw_data", {24'd0, d_log[d_log.size() - 4 + k]}, 32'h11 + k);
      end
      chk("bw_rsp", n_rsp - r0, 32'd4);
      chk("bw_last_once", n_rsp_last - rl0, 32'd1);
      chk("bw_last_final", {31'd0, last_rsp_last}, 32'd1);

      // burst read with ready stuck low: timeout aborts the command
      bus_rdy = 1'b0; s0 = n_strobe; r0 = n_rsp;
      issue(20'hC0000, 1'b1, 1'b0, 8'd2, 1'b1);
      wait_idle();
      repeat (50) @(posedge clk);
      #1;
      chk("to_width", last_width, 32'd64);
      chk("to_count", n_strobe - s0, 32'd1);
      chk("to_rsp", n_rsp - r0, 32'd1);
      chk("to_flags", {30'd0, last_rsp_last, last_rsp_tmo}, 32'h3);
      chk("to_idle", {31'd0, cmd_ready}, 32'd1);

      // reset asserted in the middle of a write strobe
      issue(20'h00300, 1'b0, 1'b1, 8'd0, 1'b0);
      send_wdata(8'h55, 0);
      wait_strobe();
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_rst_doe", {31'd0, bus_d_oe}, 32'd1);
      #2 reset_l = 1'b0;
      #1;
      chk("mid_rst_strobes", {28'd0, strb_s}, 32'hF);
      chk("mid_rst_aen", {31'd0, bus_aen}, 32'd1);
      chk("mid_rst_doe", {31'd0, bus_d_oe}, 32'd0);
      chk("mid_rst_addr", {12'd0, bus_a}, 32'd0);
      bus_rdy = 1'b1;
      @(posedge clk); #1;
      reset_l = 1'b1;
      chk("post_rst_ready_lo", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
      chk("post_rst_ready_hi", {31'd0, cmd_ready}, 32'd1);
      s0 = n_strobe; r0 = n_rsp;
      issue(20'h12345, 1'b0, 1'b0, 8'd0, 1'b0);
      send_wdata(8'h77, 0);
      wait_idle();
      chk("post_rst_width", last_width, 32'd8);
      chk("post_rst_type", {28'd0, last_type}, 32'hE);
      chk("post_rst_rsp", n_rsp - r0, 32'd1);
      chk("post_rst_addr", {12'd0, a_log[$]}, 32'h12345);

      // address wrap at the top of the address space
      s0 = n_strobe;
      issue(20'hFFFFF, 1'b1, 1'b0, 8'd1, 1'b1);
      wait_idle();
      chk("wrap_count", n_strobe - s0, 32'd2);
      chk("wrap_first", {12'd0, a_log[a_log.size() - 2]}, 32'hFFFFF);
      chk("wrap_second", {12'd0, a_log[a_log.size() - 1]}, 32'h00000);

      chk("one_strobe_only", n_multi, 32'd0);
      chk("strobe_aen_low", n_aen_bad, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/isa_cycle_gen.md
ISA_CYCLE_GEN -- requirements
Module: isa_cycle_gen

Interface
REQ-001 SHALL take parameters (name, default, meaning):
  ADDR_W, 20, bus address width
  DATA_W, 8, bus data width (8 or 16)
  LEN_W, 8, burst length field width
  SETUP_CLKS, 3, address/data valid before strobe asserts (clocks, min 1)
  STROBE_CLKS, 6, minimum strobe low time (clocks, min 1)
  HOLD_CLKS, 4, address/data hold after strobe release (clocks, min 1)
  TIMEOUT_CLKS, 64, maximum strobe low time while bus_rdy stays low
REQ-002 SHALL have ports (name direction width meaning), clock and reset first:
  clk  in  1  single clock domain
  reset_l  in  1  reset, asynchronous assert, active low
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted when both high
  cmd_addr  in  ADDR_W  first beat address
  cmd_read  in  1  1=read, 0=write
  cmd_io  in  1  1=I/O cycle, 0=memory cycle
  cmd_len  in  LEN_W  beat count minus one
  cmd_incr  in  1  increment address by 1 per beat
  wr_valid / wr_ready  in / out  1 / 1  write-data handshake, one per write beat
  wr_data  in  DATA_W  write beat data
  rsp_valid  out  1  one-clock pulse per completed beat
  rsp_data  out  DATA_W  read data (0 for writes)
  rsp_last  out  1  final beat of command
  rsp_timeout  out  1  beat aborted on timeout
  bus_a  out  ADDR_W  ISA address
  bus_d_out / bus_d_oe  out  DATA_W / 1  write data / drive enable
  bus_d_in  in  DATA_W  read data from bus
  bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l  out  1 each  strobes, active low
  bus_aen  out  1  low during a CPU cycle, high idle
  bus_rdy  in  1  asynchronous ready (IOCHRDY), high = ready

Function
REQ-003 SHALL implement states IDLE, WDATA, SETUP, STROBE, HOLD.
REQ-004 IDLE: cmd_ready=1; on accept latch addr, read, io, len, incr; write -> WDATA, read -> SETUP.
REQ-005 WDATA: wr_ready=1, bus_aen high, strobes high; on wr_valid latch wr_data, go SETUP; stalls indefinitely otherwise.
REQ-006 SETUP: bus_aen=0, bus_a driven, bus_d_oe=1 on writes; exactly SETUP_CLKS clocks, then STROBE.
REQ-007 STROBE: exactly one strobe low per cmd_read/cmd_io; leaves after >=STROBE_CLKS clocks on the first clock the synchronized bus_rdy is high.
REQ-008 bus_rdy SHALL pass a 2-flop synchronizer; its latency adds to strobe width, never shortens it.
REQ-009 Read data SHALL be sampled from bus_d_in on the last STROBE clock and presented on rsp_data.
REQ-010 If strobe has been low TIMEOUT_CLKS clocks with rdy low, strobe releases, the beat completes with rsp_timeout=1, rsp_last=1, and remaining beats are dropped.
REQ-011 HOLD: strobes high, bus_a and bus_d_out stable, bus_d_oe held; exactly HOLD_CLKS clocks; rsp_valid pulses on the first HOLD clock.
REQ-012 HOLD end: beats remaining -> address+1 if incr (wraps modulo 2^ADDR_W), then WDATA (write) or SETUP (read); else IDLE with bus_aen high, bus_d_oe=0.
REQ-013 Beat count is cmd_len+1; cmd_len=0 is a single cycle; max 2^LEN_W beats.
REQ-014 At most one strobe low at any time; strobes never low outside STROBE.

Reset
REQ-015 reset_l low SHALL immediately force strobes high, bus_aen=1, bus_d_oe=0, bus_a=0, bus_d_out=0, cmd_ready=0, wr_ready=0, rsp_*=0, state IDLE, synchronizer cleared, including mid-strobe.
REQ-016 cmd_ready SHALL rise on the first clock after reset_l deasserts.

Structure
REQ-017 State enum and cycle-type encoding SHALL reside in a shared package isa_pkg.
REQ-018 The rdy synchronizer SHALL be sub-module isa_sync2; timing counters stay inline.

Verification
REQ-019 I/O write 0x3D8 data 0x0B, rdy high -> bus_iow_l low exactly 8 clocks (6 min + 2 sync), bus_a=0x3D8 stable 3 clocks before to 4 clocks after, one rsp_valid.
REQ-020 Memory read 0xB8055, bus_d_in=0xAA, rdy low 10 clocks after strobe -> bus_memr_l low >=12 clocks, rsp_data=0xAA, rsp_last=1.
REQ-021 Burst write 0xB8000, cmd_len=3, incr=1, data 0x11..0x14, wr_valid gapped 5 clocks on beat 2 -> addresses B8000..B8003, four strobes, bus_aen high during gap, rsp_last on beat 4 only.
REQ-022 Burst read, rdy stuck low -> strobe released at clock 64, rsp_timeout=1, rsp_last=1, IDLE, no further strobes.
REQ-023 reset_l low mid-STROBE -> strobe high same clock edge-independent, bus_aen=1, bus_d_oe=0; next command completes normally.
REQ-024 cmd_addr 0xFFFFF, cmd_len=1, incr=1 -> second beat address 0x00000.
